alu_iterative: RTL and testbench
================================

Name: alu_iterative

Overview:
- Execute-stage ALU that consumes the 3-bit ALU control code produced by the ALU control decoder. It replaces the purely combinational ALU.
- AND/OR/ADD/SUB complete in one cycle. MUL runs as a radix-2 shift-add sequence over DATA_WIDTH cycles.
- busy_o drives the pipeline stall/PC-hold logic. data_o/zero_o feed writeback and branch compare.

Parameters:
- DATA_WIDTH, 32, operand/result width; MUL iteration count.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous active-low reset.
- start_i  input  1  request; sampled only in IDLE.
- ALUCtrl_i  input  3  op code: 000 AND, 001 OR, 010 ADD, 110 SUB, 011 MUL; others illegal.
- data1_i  input  DATA_WIDTH  operand A (multiplicand for MUL).
- data2_i  input  DATA_WIDTH  operand B (multiplier for MUL).
- data_o  output  DATA_WIDTH  registered result; held until next completion.
- zero_o  output  1  registered, equals (data_o == 0).
- busy_o  output  1  high while in MUL state.
- done_o  output  1  one-cycle pulse on the cycle data_o updates.

Behaviour:
- Reset (rst_i low at an edge): state IDLE, data_o=0, zero_o=1, busy_o=0, done_o=0, counter/accumulator/operand regs=0. Reset wins over every other event. Reset mid-MUL aborts the operation with no done_o.
- States: IDLE, MUL.
- IDLE, start_i=1, ALUCtrl_i in {000,001,010,110}:
  - At the sampling edge, data_o <= result, zero_o <= (result==0), done_o <= 1.
  - Latency 1 edge. State stays IDLE.
- IDLE, start_i=1, ALUCtrl_i=011 (MUL):
  - Latch mcand=data1_i, mplier=data2_i. Clear acc and count.
  - Enter MUL; busy_o=1 from that edge. data_o unchanged.
- IDLE, start_i=1, illegal code (100, 101, 111): data_o <= 0, zero_o <= 1, done_o <= 1. Treated as a 1-cycle op.
- IDLE, start_i=0: done_o <= 0; all else holds.
- MUL, each edge:
  - If mplier[0], then acc <= acc + mcand (mod 2^DATA_WIDTH).
  - mcand <<= 1; mplier >>= 1; count++.
- MUL termination:
  - On the edge where count == DATA_WIDTH-1, the final acc value (including this iteration) loads into data_o.
  - At the same edge: zero_o updates, done_o <= 1, busy_o <= 0, state -> IDLE.
  - MUL latency is DATA_WIDTH edges after the sampling edge (32 for default). Fixed; no early exit on zero multiplier.
- MUL result is the low DATA_WIDTH bits of the product, identical for signed and unsigned operands.
- start_i and operand/op changes while in MUL are ignored. Operands are used only as latched.
- Back-to-back operation:
  - In the cycle done_o is high the state is already IDLE, so a start_i in that cycle is accepted.
  - Consecutive 1-cycle ops keep done_o high on consecutive cycles.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow or carry output.
  - SUB computes data1_i - data2_i.
- busy_o is a registered state decode; no combinational path from inputs to any output.

Test Plan:
- Reset: hold rst_i=0 for 2 edges, then release -> data_o=0, zero_o=1, busy_o=0, done_o=0.
- ADD 0xFFFFFFFF + 0x00000001 with start_i=1 -> next edge data_o=0x00000000, zero_o=1, done_o=1 for exactly 1 cycle. SUB 0x10 - 0x3 -> data_o=0x0000000D, zero_o=0. OR 0xF0 | 0x0F -> 0xFF. AND 0xF0 & 0x0F -> 0x0, zero_o=1.
- MUL 7 × 6 -> busy_o=1 for 32 cycles; done_o high on edge 32 with data_o=42. MUL 0xFFFFFFFF × 0xFFFFFFFF -> data_o=0x00000001. MUL 0x80000000 × 2 -> data_o=0, zero_o=1.
- During MUL, pulse start_i with ADD 1+1 and change data1_i/data2_i -> ignored; MUL result unaffected. ADD issued in the done_o cycle completes one edge later (back-to-back).
- Assert rst_i=0 at cycle 10 of a MUL -> next state IDLE, busy_o=0, data_o=0, no done_o. A fresh MUL 3 × 5 afterwards -> 15 after 32 edges.
- Illegal code 3'b111 with start_i=1 -> data_o=0, zero_o=1, done_o pulse, busy_o stays 0.

Source files
------------

// File: rtl/alu_iterative.sv
// alu_iterative: execute-stage ALU driven by the 3-bit ALU control code.
// AND/OR/ADD/SUB (and illegal codes, which yield zero) complete on the
// sampling edge. MUL runs a radix-2 shift-add sequence of DATA_WIDTH edges.
// Ports:
//   clk_i      clock, all state on rising edge
//   rst_i      synchronous active-low reset
//   start_i    operation request, sampled only while idle
//   ALUCtrl_i  op code: 000 AND, 001 OR, 010 ADD, 110 SUB, 011 MUL
//   data1_i    operand A (multiplicand for MUL)
//   data2_i    operand B (multiplier for MUL)
//   data_o     registered result, held until the next completion
//   zero_o     registered (data_o == 0)
//   busy_o     high while a MUL is in progress
//   done_o     one-cycle pulse on the edge data_o updates
module alu_iterative #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [2:0]            ALUCtrl_i,
   input  logic [DATA_WIDTH-1:0] data1_i,
   input  logic [DATA_WIDTH-1:0] data2_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  zero_o,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic {
      S_IDLE,
      S_MUL
   } state_e;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b011;

   localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

   state_e                state_q;
   logic [DATA_WIDTH-1:0] mcand_q;
   logic [DATA_WIDTH-1:0] mplier_q;
   logic [DATA_WIDTH-1:0] acc_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  zero_q;
   logic                  busy_q;
   logic                  done_q;

   logic [DATA_WIDTH-1:0] alu_res_d;
   logic [DATA_WIDTH-1:0] acc_d;

   // Single-cycle result; illegal codes produce zero.
   always_comb begin
      alu_res_d = '0;
      case (ALUCtrl_i)
         OP_AND:  alu_res_d = data1_i & data2_i;
         OP_OR:   alu_res_d = data1_i | data2_i;
         OP_ADD:  alu_res_d = data1_i + data2_i;
         OP_SUB:  alu_res_d = data1_i - data2_i;
         default: alu_res_d = '0;
      endcase
   end

   // Accumulator value after the current shift-add iteration.
   always_comb begin
      acc_d = acc_q;
      if (mplier_q[0]) begin
         acc_d = acc_q + mcand_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         zero_q   <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  if (ALUCtrl_i == OP_MUL) begin
                     mcand_q  <= data1_i;
                     mplier_q <= data2_i;
                     acc_q    <= '0;
                     cnt_q    <= '0;
                     busy_q   <= 1'b1;
                     state_q  <= S_MUL;
                  end else begin
                     data_q <= alu_res_d;
                     zero_q <= (alu_res_d == '0);
                     done_q <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               done_q   <= 1'b0;
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CNT_WIDTH'(1);
               // Final iteration: publish the accumulator including this step.
               if (cnt_q == LAST_ITER) begin
                  data_q  <= acc_d;
                  zero_q  <= (acc_d == '0);
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign data_o = data_q;
   assign zero_o = zero_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Testbench for alu_iterative: directed and random operations, with a
// queue-based scoreboard checked by an independent monitor process.
module tb_alu_iterative;

   localparam int unsigned DW      = 32;
   localparam int unsigned MUL_LAT = 32;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic [2:0]    ALUCtrl_i;
   logic [DW-1:0] data1_i;
   logic [DW-1:0] data2_i;
   logic [DW-1:0] data_o;
   logic          zero_o;
   logic          busy_o;
   logic          done_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [DW-1:0] data;
      int            lat;
      logic [2:0]    op;
   } exp_t;

   exp_t exp_q[$];
   int   busy_cnt = 0;

   alu_iterative #(.DATA_WIDTH(DW), .CNT_WIDTH(6)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (start_i),
      .ALUCtrl_i (ALUCtrl_i),
      .data1_i   (data1_i),
      .data2_i   (data2_i),
      .data_o    (data_o),
      .zero_o    (zero_o),
      .busy_o    (busy_o),
      .done_o    (done_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference: plain arithmetic on the op code, low DW bits of the product.
   function automatic logic [DW-1:0] model(input logic [2:0] op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
      logic [2*DW-1:0] prod;
      prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      case (op)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b011:  return prod[DW-1:0];
         default: return '0;
      endcase
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation per done_o pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (rst_i !== 1'b1) begin
            busy_cnt = 0;
         end else begin
            if (busy_o === 1'b1) busy_cnt++;
            if (done_o === 1'b1) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("data op=%b", e.op), data_o, e.data);
                  check($sformatf("zero op=%b", e.op), {31'd0, zero_o},
                        {31'd0, (e.data == '0)});
                  check($sformatf("busy_cycles op=%b", e.op), busy_cnt, e.lat);
                  check("busy_at_done", {31'd0, busy_o}, 32'd0);
               end
               busy_cnt = 0;
            end
         end
      end
   end

   // Drive ignored traffic while the DUT is busy.
   task automatic noise();
      start_i   = 1'($urandom_range(0, 1));
      ALUCtrl_i = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'($urandom_range(0, 7));
      data1_i   = $urandom;
      data2_i   = $urandom;
   endtask

   // Called at a negedge; waits out any MUL, then presents one request.
   task automatic issue(input logic [2:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
      exp_t e;
      int   n;
      n = 0;
      while (busy_o === 1'b1 && n < 40) begin
         noise();
         @(negedge clk_i);
         n++;
      end
      if (busy_o !== 1'b0) check("busy_timeout", {31'd0, busy_o}, 32'd0);
      start_i   = 1'b1;
      ALUCtrl_i = op;
      data1_i   = a;
      data2_i   = b;
      e.data = model(op, a, b);
      e.lat  = (op == 3'b011) ? MUL_LAT : 0;
      e.op   = op;
      exp_q.push_back(e);
      @(negedge clk_i);
   endtask

   task automatic idle(input int n);
      int k;
      k = 0;
      start_i = 1'b0;
      while (k < n || (busy_o === 1'b1 && k < n + 40)) begin
         @(negedge clk_i);
         k++;
      end
   endtask

   function automatic logic [DW-1:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_i     = 1'b0;
      start_i   = 1'b0;
      ALUCtrl_i = 3'b000;
      data1_i   = '0;
      data2_i   = '0;

      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_data", data_o, 32'd0);
      check("rst_zero", {31'd0, zero_o}, 32'd1);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_done", {31'd0, done_o}, 32'd0);
      rst_i = 1'b1;
      @(negedge clk_i);
      check("post_rst_done", {31'd0, done_o}, 32'd0);

      // Directed single-cycle ops, back-to-back.
      issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
      issue(3'b110, 32'h10, 32'h3);
      issue(3'b001, 32'hF0, 32'h0F);
      issue(3'b000, 32'hF0, 32'h0F);
      idle(2);

      // Directed MULs; next op issued in the done cycle.
      issue(3'b011, 32'd7, 32'd6);
      issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(3'b011, 32'h8000_0000, 32'd2);
      issue(3'b010, 32'd1, 32'd1);
      idle(2);

      // Illegal code.
      issue(3'b111, 32'h1234_5678, 32'h9ABC_DEF0);
      idle(2);
      check("illegal_busy", {31'd0, busy_o}, 32'd0);

      // Reset at cycle 10 of a MUL aborts with no done.
      issue(3'b011, 32'hDEAD_BEEF, 32'h0000_0003);
      repeat (9) begin
         noise();
         @(negedge clk_i);
      end
      void'(exp_q.pop_back());
      rst_i   = 1'b0;
      start_i = 1'b0;
      @(negedge clk_i);
      check("abort_busy", {31'd0, busy_o}, 32'd0);
      check("abort_data", data_o, 32'd0);
      check("abort_zero", {31'd0, zero_o}, 32'd1);
      check("abort_done", {31'd0, done_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      check("abort_no_done", {31'd0, done_o}, 32'd0);
      issue(3'b011, 32'd3, 32'd5);
      idle(2);

      // Random traffic.
      for (int i = 0; i < 150; i++) begin
         issue(3'($urandom_range(0, 7)), rand_operand(), rand_operand());
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end

      idle(3);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
